// File: rtl/link_tx_arb_if.sv
// Requester and serial-sender side signals of the shared link arbiter.
// slave is the arbiter's view; master is the requesters'/sender's view.
interface link_tx_arb_if #(
  parameter int DW = 4
) ();
  logic          req0;
  logic [DW-1:0] data0;
  logic          req1;
  logic [DW-1:0] data1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] p2s_din;
  logic          p2s_load;
  logic          p2s_send;
  logic          busy;

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, done0, done1, p2s_din, p2s_load, p2s_send, busy
  );

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, done0, done1, p2s_din, p2s_load, p2s_send, busy
  );
endinterface

// File: rtl/link_tx_arb.sv
// Two-requester round-robin arbiter that sequences the serial sender through
// LOAD -> SEND -> GAP frames and pulses done to the requester it served.
module link_tx_arb #(
  parameter int DW      = 4,
  parameter int GAP_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  link_tx_arb_if.slave  lnk
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  // One counter serves both SEND bits and GAP cycles, so it is sized for the larger.
  localparam int CW_SEND = $clog2(DW + 1);
  localparam int CW_GAP  = $clog2(GAP_CYC + 1);
  localparam int CW      = (CW_SEND > CW_GAP) ? CW_SEND : CW_GAP;

  localparam logic [CW-1:0] SEND_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] word, word_n;
  logic          last_served, last_n;
  logic          pick1;

  logic          gnt0_r, gnt1_r, done0_r, done1_r;
  logic          load_r, send_r, busy_r;
  logic [DW-1:0] din_r;

  logic          gnt0_n, gnt1_n, done0_n, done1_n;
  logic          load_n, send_n, busy_n;
  logic [DW-1:0] din_n;
  logic          owns_n, frame_end;

  // last_served doubles as the current owner: it is written at grant time.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    last_n  = last_served;
    pick1   = 1'b0;
    case (state)
      IDLE: begin
        if (lnk.req0 || lnk.req1) begin
          pick1   = lnk.req1 && (!lnk.req0 || !last_served);
          word_n  = pick1 ? lnk.data1 : lnk.data0;
          last_n  = pick1;
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        state_n = SEND;
        cnt_n   = '0;
      end
      SEND: begin
        if (cnt == SEND_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    owns_n    = (state_n == LOAD) || (state_n == SEND);
    frame_end = (state == SEND) && (state_n == GAP);
    gnt0_n    = owns_n && !last_n;
    gnt1_n    = owns_n &&  last_n;
    done0_n   = frame_end && !last_served;
    done1_n   = frame_end &&  last_served;
    load_n    = (state_n == LOAD);
    send_n    = (state_n == SEND);
    busy_n    = (state_n != IDLE);
    din_n     = owns_n ? word_n : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word        <= '0;
      last_served <= 1'b1;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      load_r      <= 1'b0;
      send_r      <= 1'b0;
      busy_r      <= 1'b0;
      din_r       <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      word        <= word_n;
      last_served <= last_n;
      gnt0_r      <= gnt0_n;
      gnt1_r      <= gnt1_n;
      done0_r     <= done0_n;
      done1_r     <= done1_n;
      load_r      <= load_n;
      send_r      <= send_n;
      busy_r      <= busy_n;
      din_r       <= din_n;
    end
  end

  assign lnk.gnt0     = gnt0_r;
  assign lnk.gnt1     = gnt1_r;
  assign lnk.done0    = done0_r;
  assign lnk.done1    = done1_r;
  assign lnk.p2s_load = load_r;
  assign lnk.p2s_send = send_r;
  assign lnk.busy     = busy_r;
  assign lnk.p2s_din  = din_r;

endmodule

// File: tb/tb_link_tx_arb.sv
// Directed bench for link_tx_arb with DW=4, GAP_CYC=1 (7-cycle frame period).
module tb_link_tx_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  link_tx_arb_if #(.DW(4)) lnk ();

  link_tx_arb #(.DW(4), .GAP_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed view: {gnt0, gnt1, done0, done1, load, send, busy, din[3:0]}
  function automatic logic [15:0] ev(input bit g0, input bit g1, input bit d0,
                                     input bit d1, input bit ld, input bit sd,
                                     input bit bz, input logic [3:0] din);
    return {5'b0, g0, g1, d0, d1, ld, sd, bz, din};
  endfunction

  function automatic logic [15:0] obs();
    return {5'b0, lnk.gnt0, lnk.gnt1, lnk.done0, lnk.done1,
            lnk.p2s_load, lnk.p2s_send, lnk.busy, lnk.p2s_din};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lnk.req0 = 1'b0;
    lnk.req1 = 1'b0;
    @(negedge clk);
    chk("reset", obs(), ev(0, 0, 0, 0, 0, 0, 0, 4'h0));
    rst = 1'b0;
  endtask

  // Starts in the IDLE cycle where the grant is sampled; ends in the next IDLE cycle.
  task automatic run_frame(input string tag, input bit who, input logic [3:0] w,
                           input bit drop, input bit gap_req, input logic [3:0] gw);
    logic [3:0] rx;
    rx = 4'h0;
    @(negedge clk);
    chk({tag, "_load"}, obs(), ev(!who, who, 0, 0, 1, 0, 1, w));
    if (drop) begin
      lnk.req0  = 1'b0;
      lnk.req1  = 1'b0;
      lnk.data0 = ~lnk.data0;
      lnk.data1 = ~lnk.data1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_send"}, obs(), ev(!who, who, 0, 0, 0, 1, 1, w));
      rx[k] = lnk.p2s_din[k];
    end
    @(negedge clk);
    chk({tag, "_gap"}, obs(), ev(0, 0, !who, who, 0, 0, 1, 4'h0));
    chk({tag, "_rx"}, {12'h0, rx}, {12'h0, w});
    if (gap_req) begin
      lnk.req0  = 1'b1;
      lnk.data0 = gw;
    end
    @(negedge clk);
    chk({tag, "_idle"}, obs(), ev(0, 0, 0, 0, 0, 0, 0, 4'h0));
  endtask

  initial begin
    lnk.req0  = 1'b0;
    lnk.req1  = 1'b0;
    lnk.data0 = 4'h0;
    lnk.data1 = 4'h0;

    // Single frame from requester 0, request pulsed for one cycle
    do_reset();
    lnk.req0  = 1'b1;
    lnk.data0 = 4'b1011;
    run_frame("single0", 1'b0, 4'b1011, 1'b1, 1'b0, 4'h0);

    // Both held: strict alternation starting with requester 0
    do_reset();
    lnk.req0  = 1'b1;
    lnk.req1  = 1'b1;
    lnk.data0 = 4'hA;
    lnk.data1 = 4'h5;
    run_frame("rr_a", 1'b0, 4'hA, 1'b0, 1'b0, 4'h0);
    run_frame("rr_b", 1'b1, 4'h5, 1'b0, 1'b0, 4'h0);
    run_frame("rr_c", 1'b0, 4'hA, 1'b0, 1'b0, 4'h0);
    lnk.req0 = 1'b0;
    lnk.req1 = 1'b0;
    @(negedge clk);
    chk("rr_stop", obs(), ev(0, 0, 0, 0, 0, 0, 0, 4'h0));

    // Requester 1 alone for three frames, new word each frame
    lnk.req1  = 1'b1;
    lnk.data1 = 4'h6;
    run_frame("solo1_a", 1'b1, 4'h6, 1'b0, 1'b0, 4'h0);
    lnk.data1 = 4'h9;
    run_frame("solo1_b", 1'b1, 4'h9, 1'b0, 1'b0, 4'h0);
    lnk.data1 = 4'hE;
    run_frame("solo1_c", 1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
    lnk.req1 = 1'b0;

    // Data changed after grant (3 -> C) must not reach the frame
    lnk.req0  = 1'b1;
    lnk.data0 = 4'h3;
    run_frame("datachg", 1'b0, 4'h3, 1'b1, 1'b0, 4'h0);

    // Reset in the second SEND cycle abandons the frame
    do_reset();
    lnk.req0  = 1'b1;
    lnk.data0 = 4'h7;
    @(negedge clk);
    chk("rstmid_load", obs(), ev(1, 0, 0, 0, 1, 0, 1, 4'h7));
    lnk.req0 = 1'b0;
    @(negedge clk);
    chk("rstmid_send1", obs(), ev(1, 0, 0, 0, 0, 1, 1, 4'h7));
    @(negedge clk);
    chk("rstmid_send2", obs(), ev(1, 0, 0, 0, 0, 1, 1, 4'h7));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_clear", obs(), ev(0, 0, 0, 0, 0, 0, 0, 4'h0));
    rst = 1'b0;
    lnk.req0  = 1'b1;
    lnk.req1  = 1'b1;
    lnk.data0 = 4'h2;
    lnk.data1 = 4'hD;
    run_frame("rst_rr", 1'b0, 4'h2, 1'b1, 1'b0, 4'h0);

    // Request raised only during GAP is served from the first IDLE cycle
    lnk.req1  = 1'b1;
    lnk.data1 = 4'h8;
    run_frame("gapreq1", 1'b1, 4'h8, 1'b1, 1'b1, 4'h6);
    run_frame("gapreq0", 1'b0, 4'h6, 1'b1, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/link_tx_arb.md
Name: link_tx_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared serial link (parallel-to-serial sender feeding the serial-to-parallel receiver).
- Grants the link to one requester at a time and latches its word.
- Drives the sender's din/load/send controls through a fixed LOAD -> SEND -> GAP frame.
- Returns a one-cycle done pulse to the served requester.

Parameters:
- DW, 4: word width; equals the number of serial bit cycles per frame. Legal range is 2 or more.
- GAP_CYC, 1: idle cycles between frames. Legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0  in  1  requester 0 request, level.
- data0  in  DW  requester 0 word; sampled only in the grant cycle.
- req1  in  1  requester 1 request, level.
- data1  in  DW  requester 1 word; sampled only in the grant cycle.
- gnt0  out  1  requester 0 owns the link; high in LOAD and SEND.
- gnt1  out  1  requester 1 owns the link; high in LOAD and SEND.
- done0  out  1  one-cycle pulse when the requester 0 frame completes.
- done1  out  1  one-cycle pulse when the requester 1 frame completes.
- p2s_din  out  DW  word to the sender; holds the latched word from LOAD through SEND, 0 otherwise.
- p2s_load  out  1  sender load strobe.
- p2s_send  out  1  sender shift enable.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- On rst, in any state including mid-frame, on the next edge:
  - state = IDLE, bit counter = 0, latched word = 0.
  - all outputs = 0.
  - last_served = 1, so requester 0 wins the first contention.
- An in-flight frame is abandoned on reset; no done pulse is issued for it.
- State machine is IDLE, LOAD, SEND, GAP.
- IDLE:
  - Requests are sampled each cycle.
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester not equal to last_served.
  - On grant, at that edge: latch the granted data, set last_served, set the gnt bit, p2s_load=1, p2s_send=0, go to LOAD.
- LOAD (1 cycle): p2s_load=1, p2s_send=0, p2s_din=latched word, gnt held. Next state is SEND with counter = 0.
- SEND (exactly DW cycles):
  - p2s_load=0, p2s_send=1, gnt held.
  - Counter increments each cycle; its width is ceil(log2(DW+1)).
  - When counter == DW-1, go to GAP.
- GAP (GAP_CYC cycles):
  - gnt=0, p2s_send=0, p2s_load=0, p2s_din=0.
  - The matching doneN is 1 in the first GAP cycle only.
  - Counter counts GAP cycles, then returns to IDLE.
- Latency and frame spacing:
  - Req high in IDLE cycle t gives LOAD at t+1, SEND at t+2 .. t+1+DW, done at t+2+DW.
  - The earliest next grant is sampled in IDLE at t+2+DW+GAP_CYC.
  - Frame period with req held: 2+DW+GAP_CYC cycles.
- Boundary conditions:
  - Req dropped mid-frame: ignored; the frame completes and done still pulses.
  - Data changes after grant: ignored.
  - Requests in LOAD, SEND or GAP: not sampled; they are evaluated at IDLE only.
  - A requester holding req after done is re-arbitrated as a new request. When both requesters are active, round-robin guarantees alternation.
  - Exactly one of gnt0 and gnt1 can be high at a time. done0 and done1 never assert together.
  - The sender shifts LSB first, so serial bit k of a frame equals latched word bit k.

Test Plan:
- Reset, then req0=1 with data0=4'b1011 for 1 cycle -> gnt0 and p2s_load at cycle 1; p2s_send cycles 2-5; done0 at cycle 6; receiver dout=4'b1011 after the frame; busy cycles 1-6.
- req0 and req1 rise together (data0=4'hA, data1=4'h5) and are held -> grants gnt0 then gnt1 then gnt0 ...; 7-cycle period with DW=4, GAP_CYC=1; done pulses alternate.
- req1 held alone for 3 frames -> gnt1 every 7 cycles; gnt0 and done0 stay 0; p2s_din=data1 value latched at each grant.
- req0 pulsed 1 cycle and data0 changed from 4'h3 to 4'hC during SEND -> frame carries 4'h3; done0 still pulses.
- rst asserted at the 2nd SEND cycle -> next cycle all outputs 0, state IDLE, no done; following simultaneous request -> gnt0 wins.
- Requests asserted only during GAP -> no grant until IDLE; grant occurs in the first IDLE cycle after the gap.
